// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and constants for the data memory controller
package data_mem_pkg;

  // Controller states: sweeping the array, or serving requests.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Supported registered read latencies.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

endpackage

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - request/response bundle between a client and the data memory
interface data_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  clear_req;
  logic                  init_busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, clear_req,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, clear_req,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/data_mem_rsp_pipe.sv
// rtl/data_mem_rsp_pipe.sv - fixed-latency shift of read responses
module data_mem_rsp_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  vld_q [LATENCY];
  logic                  err_q [LATENCY];
  logic [DATA_WIDTH-1:0] dat_q [LATENCY];

  // Valid shifts every cycle; payload only moves with a valid so the last stage holds between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        err_q[0] <= in_err;
        dat_q[0] <= in_data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          err_q[i] <= err_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - single-port data memory with clear sweep and range check
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    DEPTH        = 64,
  parameter int                    ADDR_WIDTH   = $clog2(DEPTH),
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input logic       clk,
  input logic       rst_n,
  data_mem_if.slave bus
);

  // Out-of-range latencies are pulled to the nearest supported value.
  localparam int LAT = (READ_LATENCY < LAT_MIN) ? LAT_MIN :
                       (READ_LATENCY > LAT_MAX) ? LAT_MAX : READ_LATENCY;
  // One extra bit so DEPTH itself is representable for the range check.
  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_LINE = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                  addr_ok, accept, wr_fire, rd_fire;
  logic [DATA_WIDTH-1:0] rd_data;

  assign addr_ok = {1'b0, bus.req_addr} < DEPTH_X;
  assign accept  = bus.req_valid && bus.req_ready;
  assign wr_fire = accept && bus.req_write && addr_ok;
  assign rd_fire = accept && !bus.req_write;
  assign rd_data = addr_ok ? mem[bus.req_addr] : '0;

  // State and sweep pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Sweep sequencing, clear command and handshake outputs.
  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    bus.req_ready = 1'b0;
    bus.init_busy = 1'b0;
    case (state_q)
      CLEAR: begin
        bus.init_busy = 1'b1;
        clr_ptr_d     = clr_ptr_q + ADDR_WIDTH'(1);
        if (clr_ptr_q == LAST_LINE) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
        end
      end
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.clear_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Array write port: sweep writes while clearing, accepted in-range writes otherwise.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem[clr_ptr_q] <= CLEAR_VALUE;
      end else if (wr_fire) begin
        mem[bus.req_addr] <= bus.req_wdata;
      end
    end
  end

  data_mem_rsp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (LAT)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_fire),
    .in_err    (!addr_ok),
    .in_data   (rd_data),
    .out_valid (bus.rsp_valid),
    .out_err   (bus.rsp_err),
    .out_data  (bus.rsp_rdata)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  int         sel;
  logic       req_valid, req_write, clear_req;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready, init_busy, rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;

  always #5 clk = ~clk;

  data_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus0 ();
  data_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus1 ();
  data_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus2 ();

  assign bus0.req_valid = req_valid && (sel == 0);
  assign bus1.req_valid = req_valid && (sel == 1);
  assign bus2.req_valid = req_valid && (sel == 2);
  assign bus0.clear_req = clear_req && (sel == 0);
  assign bus1.clear_req = clear_req && (sel == 1);
  assign bus2.clear_req = clear_req && (sel == 2);
  assign bus0.req_write = req_write;
  assign bus1.req_write = req_write;
  assign bus2.req_write = req_write;
  assign bus0.req_addr  = req_addr;
  assign bus1.req_addr  = req_addr;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_wdata = req_wdata;
  assign bus2.req_wdata = req_wdata;

  data_mem_ctrl #(.DATA_WIDTH(8), .DEPTH(64), .ADDR_WIDTH(6), .READ_LATENCY(1), .CLEAR_VALUE(8'h00))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  data_mem_ctrl #(.DATA_WIDTH(8), .DEPTH(64), .ADDR_WIDTH(6), .READ_LATENCY(2), .CLEAR_VALUE(8'h00))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  data_mem_ctrl #(.DATA_WIDTH(8), .DEPTH(48), .ADDR_WIDTH(6), .READ_LATENCY(2), .CLEAR_VALUE(8'h00))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Route the selected instance's outputs to the checker.
  always_comb begin
    req_ready = bus0.req_ready;
    init_busy = bus0.init_busy;
    rsp_valid = bus0.rsp_valid;
    rsp_rdata = bus0.rsp_rdata;
    rsp_err   = bus0.rsp_err;
    if (sel == 1) begin
      req_ready = bus1.req_ready;
      init_busy = bus1.init_busy;
      rsp_valid = bus1.rsp_valid;
      rsp_rdata = bus1.rsp_rdata;
      rsp_err   = bus1.rsp_err;
    end else if (sel == 2) begin
      req_ready = bus2.req_ready;
      init_busy = bus2.init_busy;
      rsp_valid = bus2.rsp_valid;
      rsp_rdata = bus2.rsp_rdata;
      rsp_err   = bus2.rsp_err;
    end
  end

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  int         checks = 0;
  int         failures = 0;
  int         depth, lat, busy, cyc;
  bit         known;
  logic [7:0] mem_m [64];
  rsp_t       exp_q [$];
  logic [7:0] hold_d;
  logic       hold_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d cyc=%0d got=0x%0h expected=0x%0h", tag, sel, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    busy = depth;
    exp_q.delete();
    hold_d = 8'h00;
    hold_e = 1'b0;
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
  endtask

  // One clock: drive, check handshake, advance model, check responses.
  task automatic cycle(input logic v, input logic w, input logic [5:0] a,
                       input logic [7:0] d, input logic clr, input logic rst);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    clear_req = clr; rst_n = !rst;
    if (known) begin
      check_eq("req_ready", req_ready, busy == 0);
      check_eq("init_busy", init_busy, busy > 0);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
      known = 1'b1;
    end else if (busy > 0) begin
      busy--;
    end else begin
      if (v) begin
        if (w) begin
          if (a < depth) mem_m[a] = d;
        end else begin
          exp_q.push_back('{due: cyc + lat - 1,
                            data: (a < depth) ? mem_m[a] : 8'h00,
                            err: !(a < depth)});
        end
      end
      if (clr) begin
        busy = depth;
        for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
      end
    end
    @(negedge clk);
    if (known) begin
      bit ev;
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check_eq("rsp_valid", rsp_valid, ev);
      if (ev) begin
        hold_d = exp_q[0].data;
        hold_e = exp_q[0].err;
        void'(exp_q.pop_front());
      end
      check_eq("rsp_rdata", rsp_rdata, hold_d);
      check_eq("rsp_err", rsp_err, hold_e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [5:0] a);
    cycle(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    cycle(1'b1, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic settle(input logic v);
    for (int i = 0; i < 200 && busy > 0; i++) cycle(v, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; sel = 0; cyc = 0; known = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; clear_req = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel   = s;
      depth = (s == 2) ? 48 : 64;
      lat   = (s == 0) ? 1 : 2;
      known = 1'b0;
      exp_q.delete();
      cycle(1'b1, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1);
      settle(1'b1);
      rd(6'd0); rd(6'd31); rd(6'd63); idle(3);
      wr(6'd5, 8'hA5); rd(6'd5); idle(3);
      for (int a = 0; a < 8; a++) wr(6'(a), 8'(a + 8'h10));
      for (int a = 0; a < 8; a++) rd(6'(a));
      idle(3);
      wr(6'd50, 8'hFF); rd(6'd50); rd(6'd47); idle(3);
      wr(6'd9, 8'h3C); cycle(1'b1, 1'b0, 6'd9, 8'h00, 1'b1, 1'b0);
      settle(1'b0); rd(6'd9); idle(3);
      cycle(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0);
      idle(20);
      cycle(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1);
      settle(1'b0);
      wr(6'd3, 8'h77);
      cycle(1'b1, 1'b0, 6'd3, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1);
      settle(1'b0);
      rd(6'd3); idle(3);
      for (int i = 0; i < 300; i++) begin
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              6'($urandom_range(0, 63)), 8'($urandom),
              1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 249) == 0));
      end
      settle(1'b0);
      idle(4);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised successor to the 8-bit x 64 single-port data RAM; the data memory for the processor datapath.
- Adds a valid/ready request interface, a configurable registered read latency and an address-range check with an error flag.
- Adds a hardware clear sequencer that sweeps every line to a known value after reset or on command.
- Single port: one read or one write per cycle.

Parameters:
DATA_WIDTH, 8, bits per memory line
DEPTH, 64, number of lines (need not be a power of 2)
ADDR_WIDTH, $clog2(DEPTH) = 6, address bus width
READ_LATENCY, 1, cycles from read accept to rsp_valid; legal values 1 or 2
CLEAR_VALUE, 0, value written to every line during a clear sweep

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  line address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle pulse: rsp_rdata/rsp_err valid
rsp_rdata  output  DATA_WIDTH  read data, held between responses
rsp_err  output  1  response was to an out-of-range address
clear_req  input  1  start a clear sweep (sampled only in IDLE)
init_busy  output  1  clear sweep in progress

Behaviour:
- Reset (rst_n = 0 at posedge):
  - state = CLEAR, clr_ptr = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - In-flight read responses are discarded.
  - Memory array is not reset directly; the CLEAR sweep initialises it.
- States: CLEAR, IDLE.
  - req_ready = (state == IDLE).
  - init_busy = (state == CLEAR).
- CLEAR:
  - Each cycle writes mem[clr_ptr] = CLEAR_VALUE and increments clr_ptr.
  - The cycle that writes line DEPTH-1 transitions to IDLE.
  - init_busy is therefore high for exactly DEPTH cycles after rst_n rises.
  - Reset during CLEAR restarts the sweep at line 0.
- IDLE:
  - A request is accepted at a posedge where req_valid && req_ready.
  - clear_req = 1 moves the block to CLEAR at the next edge, with clr_ptr = 0.
  - If clear_req and an accepted request occur in the same cycle, the request completes first, then the block enters CLEAR.
- Write accept:
  - mem[req_addr] <= req_wdata at the accept edge; no response is generated.
  - req_addr >= DEPTH: write dropped, memory unchanged, no response.
- Read accept:
  - Data is sampled from the array at the accept edge, so it reflects all writes accepted on earlier edges.
  - rsp_valid pulses high for one cycle, READ_LATENCY cycles after accept:
    - READ_LATENCY = 1: visible in the cycle after accept.
    - READ_LATENCY = 2: one further cycle later.
  - rsp_rdata and rsp_err update only on a response and are otherwise held.
  - req_addr >= DEPTH: response still issued, rsp_rdata = 0, rsp_err = 1.
- Throughput: back-to-back reads at one per cycle give back-to-back responses in order; no backpressure on the response side.
- Read-after-write: a write followed by a read to the same address on the next cycle returns the new data.
- Write-after-read: with READ_LATENCY = 2, a write to the same address accepted the cycle after a read does not alter that read's response (pre-write value).
- Clear vs in-flight reads: reads accepted before a clear started still produce their responses, carrying the pre-clear data.
- Width rule: DATA_WIDTH and ADDR_WIDTH carry no implicit truncation; the address range check compares the full ADDR_WIDTH value against DEPTH.

Decomposition:
- Package data_mem_pkg holds:
  - the state enum {CLEAR, IDLE};
  - the legal READ_LATENCY constants (LAT_MIN = 1, LAT_MAX = 2).
- Sub-module data_mem_rsp_pipe: a READ_LATENCY-stage shift of {valid, err, data} with synchronous active-low reset of the valid bits.
- Top level holds the array, the clear FSM and the accept logic.

Test Plan:
- Release rst_n, hold req_valid = 1 -> req_ready = 0 and init_busy = 1 for exactly 64 cycles, then req_ready = 1; reads of addresses 0, 31 and 63 all return 0x00.
- Write 0xA5 @ 5, then read 5 on the next cycle -> rsp_rdata = 0xA5, rsp_err = 0; rsp_valid is a single pulse 1 cycle after accept (2 cycles with READ_LATENCY = 2).
- Streaming reads of addresses 0..7 after writing data = addr + 0x10 -> eight consecutive rsp_valid pulses carrying 0x10..0x17 in order.
- DEPTH = 48 build: write 0xFF @ 50 -> no memory change; read 50 -> rsp_rdata = 0x00 with rsp_err = 1; read 47 -> rsp_err = 0.
- Write 0x3C @ 9, read 9, assert clear_req the same cycle -> the response carries 0x3C; init_busy then stays high for 64 cycles; a later read of 9 returns 0x00.
- Assert rst_n = 0 for 1 cycle in the middle of a sweep and with a READ_LATENCY = 2 read in flight -> no rsp_valid is seen for that read; init_busy is high for the full 64 cycles after release.
